mem_axi_arbiter: RTL and testbench
==================================

# mem_axi_arbiter

Arbitrates the instruction cache and data cache for the single 64-bit AXI4 master port to memory. It sits directly downstream of both caches and converts each cache's whole-line request into an 8-beat INCR burst:
- 64-byte line refills are assembled into the 512-bit `*_rdata` line the cache consumes.
- Dcache 512-bit writebacks are split into 8 write beats.

Only one transaction is outstanding at a time.

## Interface
Parameters:
- `LINE_BEATS`, 8, beats per 64-byte line; fixed by the 512-bit line width and 64-bit bus.
- `BEAT_BYTES`, 8, bytes per beat; drives `m_arsize`/`m_awsize`, which equal 3.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `icache_req` in 1 / `icache_grant` out 1  request/grant pair for the icache.
- `icache_araddr` in 64, `icache_arvalid` in 1, `icache_arready` out 1  icache line-read address handshake.
- `icache_rdata` out 512, `icache_rvalid` out 1  refilled line; `icache_rvalid` is a one-cycle pulse.
- `dcache_req` in 1 / `dcache_grant` out 1  request/grant pair for the dcache.
- `dcache_araddr` in 64, `dcache_arvalid` in 1, `dcache_arready` out 1  dcache line-read address handshake.
- `dcache_rdata` out 512, `dcache_rvalid` out 1  refilled line; `dcache_rvalid` is a one-cycle pulse.
- `dcache_awaddr` in 64, `dcache_awvalid` in 1, `dcache_awready` out 1  writeback address handshake.
- `dcache_wdata` in 512, `dcache_wvalid` in 1, `dcache_wready` out 1  writeback line data handshake.
- `dcache_bdone` out 1  one-cycle pulse when the writeback response is received.
- `m_araddr` out 64, `m_arlen` out 8, `m_arsize` out 3, `m_arburst` out 2, `m_arvalid` out 1, `m_arready` in 1  AXI read address channel.
- `m_rdata` in 64, `m_rlast` in 1, `m_rvalid` in 1, `m_rready` out 1  AXI read data channel.
- `m_awaddr` out 64, `m_awlen` out 8, `m_awsize` out 3, `m_awburst` out 2, `m_awvalid` out 1, `m_awready` in 1  AXI write address channel.
- `m_wdata` out 64, `m_wlast` out 1, `m_wvalid` out 1, `m_wready` in 1  AXI write data channel.
- `m_bvalid` in 1, `m_bready` out 1  AXI write response channel.

## Operation
- FSM states: IDLE, GRANT, AR, R, AW, W, B.
- **IDLE.** If any `*_req` is high, the arbiter picks a winner, sets that cache's `*_grant`, and moves to GRANT.
  - Arbitration is round-robin: a `last_winner` register resets to icache, so dcache wins the first tie.
- **GRANT.** The arbiter waits for the winner's `*_arvalid`, or for `dcache_awvalid` when dcache is the winner.
  - It captures the address with bits [5:0] forced to 0, pulses the matching `*_arready`/`dcache_awready` for one cycle, and moves to AR or AW.
  - If dcache asserts `arvalid` and `awvalid` together, the write is taken first.
- **AR.** Drives `m_arvalid` with `m_arlen=7`, `m_arsize=3`, `m_arburst=INCR(01)`. On `m_arready`: clear the beat counter and go to R.
- **R.** `m_rready=1`. Each `m_rvalid` beat is stored at `line[cnt*64 +: 64]`, then `cnt` increments.
  - On beat 7: pulse the winner's `*_rvalid` with the full line on the next cycle, drop `*_grant` in that same cycle, update `last_winner`, and return to IDLE.
  - Completion is decided by the counter alone; `m_rlast` is not used for control.
- **AW.** The arbiter requires `dcache_wvalid`, latches the 512-bit line, and pulses `dcache_wready`.
  - It drives `m_awvalid` with len 7, size 3, INCR, and goes to W on `m_awready`.
- **W.** `m_wvalid=1` with `m_wdata=wline[cnt*64 +: 64]`. Each beat advances when `m_wready` is high. `m_wlast=1` when `cnt==7`. After the last accepted beat, go to B.
- **B.** `m_bready=1`. On `m_bvalid`: pulse `dcache_bdone`, drop the grant, and return to IDLE.
- A `*_req` deasserted while granted has no effect; the transaction runs to completion.
- `*_rdata` holds the last assembled line between pulses. Both caches share the same line register; only the granted cache's `rvalid` pulses.

## Timing
- Reset value of every output is 0, including the `*_rdata` buffer; FSM returns to IDLE and `cnt` to 0.
- Reset mid-burst abandons the AXI transaction; memory is reset in the same cycle.
- Request sampled in IDLE → `*_grant` is high in the next cycle.
- `*_arvalid` seen in GRANT → `*_arready` pulses in the same cycle; `m_arvalid` is asserted in the next cycle.
- `m_arvalid`/`m_awvalid`/`m_wvalid` stay high, with stable payload, until the matching ready is sampled high.
- Minimum read latency from AR handshake to `*_rvalid` is 9 cycles: 8 beats plus 1.
- Back-to-back transactions have at least 1 idle cycle, the IDLE re-arbitration cycle.

## Configuration
- Macro: `ARB_FIXED_PRIO_EN`.
- **Defined:** dcache always wins simultaneous requests and `last_winner` is ignored.
- **Undefined:** round-robin arbitration as specified above.

## Test plan
- **Single icache refill.** icache reads 0x1234; memory returns beats 0x0..0x7 with no stalls. Required: `m_araddr=0x1200`, `m_arlen=7`, and `icache_rvalid` pulses once with `rdata[63:0]=0`, `rdata[511:448]=7`.
- **Simultaneous requests, round-robin.** `icache_req` and `dcache_req` rise together, three times in a row. Required: grant order dcache, icache, dcache. With `ARB_FIXED_PRIO_EN` defined: dcache all three times.
- **Writeback with stalls.** Writeback of a line at 0x8040 with `m_wready` toggling every cycle. Required: 8 beats in order, `m_wlast` high only on beat 7, then `dcache_bdone` pulses once after `m_bvalid`.
- **Read backpressure.** `m_arready` held low for 5 cycles. Required: `m_araddr` is stable throughout, and `m_arvalid` stays high until the handshake.
- **Reset mid-burst.** `reset` asserted after 3 read beats. Required: all outputs are 0 on the next cycle, and a fresh request then completes normally.

Source files
------------

// File: rtl/mem_axi_arbiter.sv
// rtl/mem_axi_arbiter.sv - icache/dcache line arbiter onto one 64-bit AXI4 master port
// Optional macro ARB_FIXED_PRIO_EN: dcache always wins simultaneous requests.
module mem_axi_arbiter #(
    parameter int LINE_BEATS = 8,
    parameter int BEAT_BYTES = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         icache_req,
    output logic         icache_grant,
    input  logic [63:0]  icache_araddr,
    input  logic         icache_arvalid,
    output logic         icache_arready,
    output logic [511:0] icache_rdata,
    output logic         icache_rvalid,
    input  logic         dcache_req,
    output logic         dcache_grant,
    input  logic [63:0]  dcache_araddr,
    input  logic         dcache_arvalid,
    output logic         dcache_arready,
    output logic [511:0] dcache_rdata,
    output logic         dcache_rvalid,
    input  logic [63:0]  dcache_awaddr,
    input  logic         dcache_awvalid,
    output logic         dcache_awready,
    input  logic [511:0] dcache_wdata,
    input  logic         dcache_wvalid,
    output logic         dcache_wready,
    output logic         dcache_bdone,
    output logic [63:0]  m_araddr,
    output logic [7:0]   m_arlen,
    output logic [2:0]   m_arsize,
    output logic [1:0]   m_arburst,
    output logic         m_arvalid,
    input  logic         m_arready,
    input  logic [63:0]  m_rdata,
    input  logic         m_rlast,
    input  logic         m_rvalid,
    output logic         m_rready,
    output logic [63:0]  m_awaddr,
    output logic [7:0]   m_awlen,
    output logic [2:0]   m_awsize,
    output logic [1:0]   m_awburst,
    output logic         m_awvalid,
    input  logic         m_awready,
    output logic [63:0]  m_wdata,
    output logic         m_wlast,
    output logic         m_wvalid,
    input  logic         m_wready,
    input  logic         m_bvalid,
    output logic         m_bready
);
    localparam logic [7:0] BURST_LEN  = 8'(LINE_BEATS - 1);
    localparam logic [2:0] LAST_BEAT  = 3'(LINE_BEATS - 1);
    localparam logic [2:0] BURST_SIZE = 3'($clog2(BEAT_BYTES));
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {IDLE, GRANT, AR, R, AW, W, B} state_t;

    state_t       state, state_nxt;
    logic         sel_d, last_d, pick_d;
    logic [2:0]   cnt;
    logic [63:0]  addr;
    logic [511:0] line, wline;
    logic         wline_ok, rvalid_q, bdone_q;
    logic         take_aw, take_ar, r_beat, w_beat;

    // Burst completion is counted, so m_rlast and the line-offset address bits are never consumed.
    logic unused_bits;
    assign unused_bits = &{1'b0, m_rlast, icache_araddr[5:0], dcache_araddr[5:0], dcache_awaddr[5:0]};

    always_comb begin
        state_nxt      = state;
        pick_d         = dcache_req;
        take_aw        = 1'b0;
        take_ar        = 1'b0;
        r_beat         = 1'b0;
        w_beat         = 1'b0;
        icache_arready = 1'b0;
        dcache_arready = 1'b0;
        dcache_awready = 1'b0;
        dcache_wready  = 1'b0;
        m_arvalid      = 1'b0;
        m_rready       = 1'b0;
        m_awvalid      = 1'b0;
        m_wvalid       = 1'b0;
        m_wlast        = 1'b0;
        m_bready       = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        if (icache_req && dcache_req) pick_d = 1'b1;
`else
        if (icache_req && dcache_req) pick_d = ~last_d;
`endif
        case (state)
            IDLE: if (icache_req || dcache_req) state_nxt = GRANT;
            GRANT: begin
                // A dcache writeback outranks its own refill so the victim leaves first.
                if (sel_d && dcache_awvalid) begin
                    take_aw        = 1'b1;
                    dcache_awready = 1'b1;
                    state_nxt      = AW;
                end else if (sel_d && dcache_arvalid) begin
                    take_ar        = 1'b1;
                    dcache_arready = 1'b1;
                    state_nxt      = AR;
                end else if (!sel_d && icache_arvalid) begin
                    take_ar        = 1'b1;
                    icache_arready = 1'b1;
                    state_nxt      = AR;
                end
            end
            AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = R;
            end
            R: begin
                m_rready = 1'b1;
                r_beat   = m_rvalid;
                if (m_rvalid && cnt == LAST_BEAT) state_nxt = IDLE;
            end
            AW: begin
                dcache_wready = dcache_wvalid && !wline_ok;
                m_awvalid     = wline_ok;
                if (wline_ok && m_awready) state_nxt = W;
            end
            W: begin
                m_wvalid = 1'b1;
                m_wlast  = (cnt == LAST_BEAT);
                w_beat   = m_wready;
                if (m_wready && cnt == LAST_BEAT) state_nxt = B;
            end
            B: begin
                m_bready = 1'b1;
                if (m_bvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_d    <= 1'b0;
            last_d   <= 1'b0;
            cnt      <= 3'd0;
            addr     <= 64'd0;
            line     <= 512'd0;
            wline    <= 512'd0;
            wline_ok <= 1'b0;
            rvalid_q <= 1'b0;
            bdone_q  <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            bdone_q  <= 1'b0;
            if (state == IDLE && (icache_req || dcache_req)) sel_d <= pick_d;
            if (take_aw)      addr <= {dcache_awaddr[63:6], 6'd0};
            else if (take_ar) addr <= sel_d ? {dcache_araddr[63:6], 6'd0} : {icache_araddr[63:6], 6'd0};
            if (state == GRANT) wline_ok <= 1'b0;
            if (dcache_wready) begin
                wline    <= dcache_wdata;
                wline_ok <= 1'b1;
            end
            if ((state == AR && state_nxt == R) || (state == AW && state_nxt == W)) cnt <= 3'd0;
            if (r_beat) begin
                line[{cnt, 6'd0} +: 64] <= m_rdata;
                cnt <= cnt + 3'd1;
            end
            if (w_beat) cnt <= cnt + 3'd1;
            if (r_beat && cnt == LAST_BEAT) begin
                rvalid_q <= 1'b1;
                last_d   <= sel_d;
            end
            if (state == B && m_bvalid) begin
                bdone_q <= 1'b1;
                last_d  <= sel_d;
            end
        end
    end

    // Grants follow the FSM, so they drop in the same cycle the completion pulse appears.
    assign icache_grant  = (state != IDLE) && !sel_d;
    assign dcache_grant  = (state != IDLE) && sel_d;
    assign icache_rdata  = line;
    assign dcache_rdata  = line;
    assign icache_rvalid = rvalid_q && !sel_d;
    assign dcache_rvalid = rvalid_q && sel_d;
    assign dcache_bdone  = bdone_q;

    assign m_araddr  = addr;
    assign m_arlen   = m_arvalid ? BURST_LEN  : 8'd0;
    assign m_arsize  = m_arvalid ? BURST_SIZE : 3'd0;
    assign m_arburst = m_arvalid ? BURST_INCR : 2'd0;
    assign m_awaddr  = addr;
    assign m_awlen   = m_awvalid ? BURST_LEN  : 8'd0;
    assign m_awsize  = m_awvalid ? BURST_SIZE : 3'd0;
    assign m_awburst = m_awvalid ? BURST_INCR : 2'd0;
    assign m_wdata   = m_wvalid ? wline[{cnt, 6'd0} +: 64] : 64'd0;
endmodule

// File: tb/tb_mem_axi_arbiter.sv
// tb/tb_mem_axi_arbiter.sv - randomized scoreboard bench for mem_axi_arbiter
module tb_mem_axi_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic icache_req, icache_grant, icache_arvalid, icache_arready, icache_rvalid;
    logic [63:0] icache_araddr;
    logic [511:0] icache_rdata;
    logic dcache_req, dcache_grant, dcache_arvalid, dcache_arready, dcache_rvalid;
    logic [63:0] dcache_araddr, dcache_awaddr;
    logic [511:0] dcache_rdata, dcache_wdata;
    logic dcache_awvalid, dcache_awready, dcache_wvalid, dcache_wready, dcache_bdone;
    logic [63:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [7:0] m_arlen, m_awlen;
    logic [2:0] m_arsize, m_awsize;
    logic [1:0] m_arburst, m_awburst;
    logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    always #5 clk = ~clk;

    mem_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .icache_req(icache_req), .icache_grant(icache_grant), .icache_araddr(icache_araddr),
        .icache_arvalid(icache_arvalid), .icache_arready(icache_arready),
        .icache_rdata(icache_rdata), .icache_rvalid(icache_rvalid),
        .dcache_req(dcache_req), .dcache_grant(dcache_grant), .dcache_araddr(dcache_araddr),
        .dcache_arvalid(dcache_arvalid), .dcache_arready(dcache_arready),
        .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid),
        .dcache_awaddr(dcache_awaddr), .dcache_awvalid(dcache_awvalid), .dcache_awready(dcache_awready),
        .dcache_wdata(dcache_wdata), .dcache_wvalid(dcache_wvalid), .dcache_wready(dcache_wready),
        .dcache_bdone(dcache_bdone),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    logic any_out;
    assign any_out = |{icache_grant, icache_arready, icache_rdata, icache_rvalid,
                       dcache_grant, dcache_arready, dcache_rdata, dcache_rvalid,
                       dcache_awready, dcache_wready, dcache_bdone,
                       m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
                       m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
                       m_wdata, m_wlast, m_wvalid, m_bready};

    typedef struct { bit d; logic [511:0] line; } rd_exp_t;
    rd_exp_t     exp_rd[$];
    bit          exp_grant[$];
    logic [63:0] exp_ar[$], exp_aw[$], exp_w[$];
    int          exp_b = 0;
    int          vectors = 0, miscompares = 0;
    bit          model_last = 1'b0;
    int          data_mode = 0, ar_stall_cfg = 0, aw_rand = 0, r_gap_cfg = 0, w_mode = 0, b_delay_cfg = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] la, input int beat);
        if (data_mode == 0) return 64'(beat);
        return (la ^ 64'h9e37_79b9_7f4a_7c15) + 64'h0101_0101_0101_0101 * 64'(beat + 1);
    endfunction

    function automatic logic [511:0] model_line(input logic [63:0] a);
        logic [511:0] l;
        logic [63:0] la;
        la = {a[63:6], 6'd0};
        for (int b = 0; b < 8; b++) l[b*64 +: 64] = mem_word(la, b);
        return l;
    endfunction

    function automatic bit model_pick(input bit ireq, input bit dreq);
        if (ireq && dreq) begin
`ifdef ARB_FIXED_PRIO_EN
            return 1'b1;
`else
            return !model_last;
`endif
        end
        return dreq;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Memory slave: handshakes are judged from values captured just before each rising edge.
    logic c_rst, c_arv, c_arr, c_rv, c_rr, c_wv, c_wr, c_bv, c_br;
    logic [63:0] c_araddr;
    always @(negedge clk) begin
        c_rst = reset; c_arv = m_arvalid; c_arr = m_arready; c_araddr = m_araddr;
        c_rv = m_rvalid; c_rr = m_rready; c_wv = m_wvalid; c_wr = m_wready;
        c_bv = m_bvalid; c_br = m_bready;
    end

    initial begin
        bit rd_active, ar_seen, b_pend, w_tog;
        int rd_beat, ar_left, w_cnt, b_left;
        logic [63:0] rd_addr;
        rd_active = 0; ar_seen = 0; b_pend = 0; w_tog = 0;
        rd_beat = 0; ar_left = 0; w_cnt = 0; b_left = 0; rd_addr = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0;
        forever begin
            @(posedge clk); #1;
            if (c_rst) begin
                rd_active = 0; ar_seen = 0; b_pend = 0; w_cnt = 0; rd_beat = 0;
                m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0;
                m_awready = 0; m_wready = 0; m_bvalid = 0;
            end else begin
                if (c_arv && c_arr) begin rd_active = 1; rd_beat = 0; rd_addr = c_araddr; ar_seen = 0; end
                if (c_rv && c_rr) begin rd_beat++; if (rd_beat == 8) rd_active = 0; end
                if (c_wv && c_wr) begin
                    w_cnt++;
                    if (w_cnt == 8) begin w_cnt = 0; b_pend = 1; b_left = b_delay_cfg; end
                end
                if (c_bv && c_br) b_pend = 0;
                if (m_arvalid) begin
                    if (!ar_seen) begin ar_seen = 1; ar_left = ar_stall_cfg; end
                    m_arready = (ar_left == 0);
                    if (ar_left > 0) ar_left--;
                end else m_arready = 0;
                m_rvalid  = rd_active && (r_gap_cfg == 0 || $urandom_range(0, 1) == 1);
                m_rdata   = rd_active ? mem_word(rd_addr, rd_beat) : 64'd0;
                m_rlast   = rd_active && rd_beat == 7;
                m_awready = m_awvalid && (aw_rand == 0 || $urandom_range(0, 1) == 1);
                w_tog     = ~w_tog;
                m_wready  = m_wvalid && (w_mode == 0 || (w_mode == 1 && w_tog) ||
                                         (w_mode == 2 && $urandom_range(0, 1) == 1));
                if (b_pend && b_left > 0) begin m_bvalid = 0; b_left--; end
                else m_bvalid = b_pend;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    bit [1:0] prev_g;
    bit ar_pend, aw_pend, w_pend, e_g;
    logic [63:0] ar_hold, aw_hold, w_hold;
    int w_idx;
    rd_exp_t e_r;
    always @(negedge clk) begin
        if (reset) begin
            prev_g = 0; ar_pend = 0; aw_pend = 0; w_pend = 0; w_idx = 0;
        end else begin
            if ({dcache_grant, icache_grant} != 2'b00 && prev_g == 2'b00) begin
                if (exp_grant.size() == 0) check("grant_unexpected", 512'({dcache_grant, icache_grant}), 512'(0));
                else begin
                    e_g = exp_grant.pop_front();
                    check("grant_winner", 512'({dcache_grant, icache_grant}), 512'(e_g ? 2 : 1));
                end
            end
            prev_g = {dcache_grant, icache_grant};
            if (ar_pend) begin
                check("ar_valid_hold", 512'(m_arvalid), 512'(1));
                check("ar_addr_hold", 512'(m_araddr), 512'(ar_hold));
            end
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) check("ar_unexpected", 512'(m_arvalid), 512'(0));
                else check("ar_addr", 512'(m_araddr), 512'(exp_ar.pop_front()));
                check("ar_len_size_burst", 512'({m_arlen, m_arsize, m_arburst}), 512'({8'd7, 3'd3, 2'b01}));
            end
            ar_pend = m_arvalid && !m_arready; ar_hold = m_araddr;
            if (aw_pend) begin
                check("aw_valid_hold", 512'(m_awvalid), 512'(1));
                check("aw_addr_hold", 512'(m_awaddr), 512'(aw_hold));
            end
            if (m_awvalid && m_awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 512'(m_awvalid), 512'(0));
                else check("aw_addr", 512'(m_awaddr), 512'(exp_aw.pop_front()));
                check("aw_len_size_burst", 512'({m_awlen, m_awsize, m_awburst}), 512'({8'd7, 3'd3, 2'b01}));
            end
            aw_pend = m_awvalid && !m_awready; aw_hold = m_awaddr;
            if (w_pend) begin
                check("w_valid_hold", 512'(m_wvalid), 512'(1));
                check("w_data_hold", 512'(m_wdata), 512'(w_hold));
            end
            if (m_wvalid && m_wready) begin
                if (exp_w.size() == 0) check("w_unexpected", 512'(m_wvalid), 512'(0));
                else check("w_data", 512'(m_wdata), 512'(exp_w.pop_front()));
                check("w_last", 512'(m_wlast), 512'(w_idx == 7));
                w_idx = (w_idx + 1) % 8;
            end
            w_pend = m_wvalid && !m_wready; w_hold = m_wdata;
            if (icache_rvalid || dcache_rvalid) begin
                if (exp_rd.size() == 0) check("rvalid_unexpected", 512'({dcache_rvalid, icache_rvalid}), 512'(0));
                else begin
                    e_r = exp_rd.pop_front();
                    check("rvalid_who", 512'({dcache_rvalid, icache_rvalid}), 512'(e_r.d ? 2 : 1));
                    check("rdata_line", e_r.d ? dcache_rdata : icache_rdata, e_r.line);
                end
            end
            if (dcache_bdone) begin
                check("bdone_expected", 512'(exp_b > 0), 512'(1));
                if (exp_b > 0) exp_b--;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input bit d);
        bit got = 0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = d ? dcache_grant : icache_grant; end
        check("grant_wait", 512'(got), 512'(1));
    endtask

    task automatic addr_phase_read(input bit d, input logic [63:0] a);
        bit got = 0;
        tick();
        if (d) begin dcache_araddr = a; dcache_arvalid = 1; end
        else begin icache_araddr = a; icache_arvalid = 1; end
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = d ? dcache_arready : icache_arready; end
        check("arready_wait", 512'(got), 512'(1));
        tick();
        icache_arvalid = 0; dcache_arvalid = 0;
        if (d) dcache_req = 0; else icache_req = 0;
    endtask

    task automatic wait_rvalid(input bit d);
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin @(negedge clk); got = d ? dcache_rvalid : icache_rvalid; end
        check("rvalid_wait", 512'(got), 512'(1));
        @(negedge clk);
        check("rvalid_pulse", 512'(d ? dcache_rvalid : icache_rvalid), 512'(0));
        model_last = d;
    endtask

    task automatic push_read(input bit d, input logic [63:0] a);
        rd_exp_t t;
        t.d = d; t.line = model_line(a);
        exp_grant.push_back(d);
        exp_ar.push_back({a[63:6], 6'd0});
        exp_rd.push_back(t);
    endtask

    task automatic do_read(input bit d, input logic [63:0] a);
        push_read(d, a);
        tick();
        if (d) dcache_req = 1; else icache_req = 1;
        wait_grant(d);
        addr_phase_read(d, a);
        wait_rvalid(d);
    endtask

    task automatic tie_round(input logic [63:0] a);
        bit w, got;
        w = model_pick(1'b1, 1'b1);
        got = 0;
        push_read(w, a);
        tick();
        icache_req = 1; dcache_req = 1;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = icache_grant | dcache_grant; end
        check("tie_grant_wait", 512'(got), 512'(1));
        if (w) icache_req = 0; else dcache_req = 0;
        addr_phase_read(w, a);
        wait_rvalid(w);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [511:0] l);
        bit got = 0;
        exp_grant.push_back(1'b1);
        exp_aw.push_back({a[63:6], 6'd0});
        for (int b = 0; b < 8; b++) exp_w.push_back(l[b*64 +: 64]);
        exp_b++;
        tick(); dcache_req = 1;
        wait_grant(1'b1);
        tick(); dcache_awaddr = a; dcache_awvalid = 1;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = dcache_awready; end
        check("awready_wait", 512'(got), 512'(1));
        tick(); dcache_awvalid = 0; dcache_req = 0; dcache_wdata = l; dcache_wvalid = 1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = dcache_wready; end
        check("wready_wait", 512'(got), 512'(1));
        tick(); dcache_wvalid = 0;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin @(negedge clk); got = dcache_bdone; end
        check("bdone_wait", 512'(got), 512'(1));
        @(negedge clk);
        check("bdone_pulse", 512'(dcache_bdone), 512'(0));
        model_last = 1'b1;
    endtask

    initial begin
        int beats;
        logic [63:0] a;
        reset = 1;
        icache_req = 0; icache_araddr = 0; icache_arvalid = 0;
        dcache_req = 0; dcache_araddr = 0; dcache_arvalid = 0;
        dcache_awaddr = 0; dcache_awvalid = 0; dcache_wdata = 0; dcache_wvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs_zero", 512'(any_out), 512'(0));
        check("reset_rdata", dcache_rdata, 512'(0));
        tick(); reset = 0;

        data_mode = 0;
        do_read(1'b0, 64'h1234);
        check("refill_beat0", 512'(icache_rdata[63:0]), 512'(0));
        check("refill_beat7", 512'(icache_rdata[511:448]), 512'(7));

        data_mode = 1;
        repeat (3) tie_round({$urandom, $urandom});

        w_mode = 1; b_delay_cfg = 2;
        do_write(64'h8040, rand_line());
        w_mode = 0; b_delay_cfg = 0;

        ar_stall_cfg = 5;
        do_read(1'b1, 64'h4_0000_0abc);
        ar_stall_cfg = 0;

        a = {$urandom, $urandom};
        exp_grant.push_back(1'b0);
        exp_ar.push_back({a[63:6], 6'd0});
        tick(); icache_req = 1;
        wait_grant(1'b0);
        addr_phase_read(1'b0, a);
        beats = 0;
        for (int i = 0; i < 50 && beats < 3; i++) begin @(negedge clk); if (m_rvalid && m_rready) beats++; end
        check("reset_beats_wait", 512'(beats), 512'(3));
        tick(); reset = 1;
        @(posedge clk); @(negedge clk);
        check("midburst_outputs_zero", 512'(any_out), 512'(0));
        check("midburst_rdata", icache_rdata, 512'(0));
        tick(); reset = 0;
        model_last = 1'b0;
        do_read(1'b1, {$urandom, $urandom});

        for (int n = 0; n < 24; n++) begin
            ar_stall_cfg = $urandom_range(0, 3);
            r_gap_cfg    = $urandom_range(0, 1);
            aw_rand      = $urandom_range(0, 1);
            w_mode       = $urandom_range(0, 2);
            b_delay_cfg  = $urandom_range(0, 3);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: do_read(1'b0, a);
                1: do_read(1'b1, a);
                default: do_write(a, rand_line());
            endcase
        end

        repeat (3) @(negedge clk);
        check("exp_rd_drained", 512'(exp_rd.size()), 512'(0));
        check("exp_ar_drained", 512'(exp_ar.size()), 512'(0));
        check("exp_aw_drained", 512'(exp_aw.size()), 512'(0));
        check("exp_w_drained", 512'(exp_w.size()), 512'(0));
        check("exp_grant_drained", 512'(exp_grant.size()), 512'(0));
        check("exp_b_drained", 512'(exp_b), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
